// File: rtl/game_tick_scheduler_pkg.sv
// Shared types and constants for the game tick scheduler.
package game_tick_scheduler_pkg;

  localparam int unsigned TICK_VEL    = 0;
  localparam int unsigned TICK_POS    = 1;
  localparam int unsigned LEVEL_W     = 4;
  localparam int unsigned TICK_CNT_W  = 8;
  localparam int unsigned FRAME_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    GAP  = 2'd2,
    PH1  = 2'd3
  } state_e;

  // Frames per tick sequence for a given level, floored at div_min.
  function automatic logic [FRAME_CNT_W-1:0] calc_div(
    input logic [LEVEL_W-1:0] lvl,
    input int unsigned        div_init,
    input int unsigned        div_min
  );
    int unsigned d;
    if (32'(lvl) + div_min >= div_init) d = div_min;
    else                                d = div_init - 32'(lvl);
    return FRAME_CNT_W'(d);
  endfunction

endpackage

// File: rtl/game_tick_scheduler_frame_divider.sv
// Frame counter that turns every div-th frame pulse into a one-deep pending request.
module game_tick_scheduler_frame_divider
  import game_tick_scheduler_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_frame_pulse,
  input  logic [FRAME_CNT_W-1:0] i_div,
  input  logic                   i_consume,
  output logic                   o_req,
  output logic                   o_overrun
);

  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_req;
  logic                   r_overrun;
  logic                   w_terminal;

  // >= so that a shrinking divider never skips past its terminal count.
  assign w_terminal = i_frame_pulse && (r_frame_cnt >= i_div - FRAME_CNT_W'(1));

  // Frame counting, request hold and sticky overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_req       <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (i_frame_pulse) begin
        r_frame_cnt <= w_terminal ? '0 : r_frame_cnt + FRAME_CNT_W'(1);
      end
      if (i_consume) begin
        r_req <= w_terminal;
      end else if (w_terminal) begin
        if (r_req) r_overrun <= 1'b1;
        r_req <= 1'b1;
      end
    end
  end

  assign o_req     = r_req;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/game_tick_scheduler.sv
// Two-phase game tick sequencer with button snapshot and level progression.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_DIV_INIT = 4,
  parameter int unsigned FRAME_DIV_MIN  = 1,
  parameter int unsigned LEVEL_TICKS    = 128,
  parameter int unsigned MAX_LEVEL      = 15,
  parameter int unsigned PHASE_GAP      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_pulse,
  input  logic               button_up_raw,
  input  logic               button_down_raw,
  input  logic               game_start_pulse,
  input  logic               game_over_pulse,
  output logic [1:0]         game_tick,
  output logic               button_up,
  output logic               button_down,
  output logic [LEVEL_W-1:0] level,
  output logic               overrun
);

  localparam logic [1:0]            GAP_LAST  = 2'(PHASE_GAP - 1);
  localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(LEVEL_TICKS - 1);
  localparam logic [LEVEL_W-1:0]    LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [1:0]              r_gap_cnt;
  logic [1:0]              w_gap_cnt_nxt;
  logic [1:0]              r_game_tick;
  logic [1:0]              w_game_tick_nxt;
  logic                    w_consume;
  logic                    w_ph1_exit;
  logic                    w_req;
  logic                    w_overrun;
  logic [FRAME_CNT_W-1:0]  w_div;
  logic                    r_up_sticky;
  logic                    r_button_up;
  logic                    r_button_down;
  logic                    r_running;
  logic [LEVEL_W-1:0]      r_level;
  logic [TICK_CNT_W-1:0]   r_tick_cnt;

  assign w_div = calc_div(r_level, FRAME_DIV_INIT, FRAME_DIV_MIN);

  game_tick_scheduler_frame_divider u_frame_divider (
    .clk           (clk),
    .reset         (reset),
    .i_frame_pulse (frame_pulse),
    .i_div         (w_div),
    .i_consume     (w_consume),
    .o_req         (w_req),
    .o_overrun     (w_overrun)
  );

  // Next-state, gap counting and tick strobe decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_consume       = 1'b0;
    w_ph1_exit      = 1'b0;
    w_game_tick_nxt = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_nxt = PH0;
          w_consume   = 1'b1;
        end
      end
      PH0: begin
        w_gap_cnt_nxt = 2'd0;
        w_state_nxt   = (PHASE_GAP > 0) ? GAP : PH1;
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = PH1;
        else                       w_gap_cnt_nxt = r_gap_cnt + 2'd1;
      end
      PH1: begin
        w_state_nxt = IDLE;
        w_ph1_exit  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_game_tick_nxt[TICK_VEL] = (w_state_nxt == PH0);
    w_game_tick_nxt[TICK_POS] = (w_state_nxt == PH1);
  end

  // State register with the tick strobe registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gap_cnt   <= 2'd0;
      r_game_tick <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_game_tick <= w_game_tick_nxt;
    end
  end

  // Button snapshot taken as each sequence starts; presses in between are kept sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_sticky   <= 1'b0;
      r_button_up   <= 1'b0;
      r_button_down <= 1'b0;
    end else if (w_consume) begin
      r_button_up   <= r_up_sticky | button_up_raw;
      r_button_down <= button_down_raw;
      r_up_sticky   <= 1'b0;
    end else if (button_up_raw) begin
      r_up_sticky <= 1'b1;
    end
  end

  // Running flag and level progression; game over beats game start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running  <= 1'b0;
      r_level    <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (game_over_pulse)       r_running <= 1'b0;
      else if (game_start_pulse) r_running <= 1'b1;

      if (game_start_pulse) begin
        r_level    <= '0;
        r_tick_cnt <= '0;
      end else if (w_ph1_exit && r_running) begin
        if (r_tick_cnt == TICK_LAST) begin
          r_tick_cnt <= '0;
          if (r_level < LEVEL_MAX) r_level <= r_level + LEVEL_W'(1);
        end else begin
          r_tick_cnt <= r_tick_cnt + TICK_CNT_W'(1);
        end
      end
    end
  end

  assign game_tick   = r_game_tick;
  assign button_up   = r_button_up;
  assign button_down = r_button_down;
  assign level       = r_level;
  assign overrun     = w_overrun;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomised bench for game_tick_scheduler against a sequence-position reference model.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_pulse;
  logic       bu_raw;
  logic       bd_raw;
  logic       start_p;
  logic       over_p;

  logic [1:0] gt0, gt1;
  logic       bu0, bu1, bd0, bd1, ov0, ov1;
  logic [3:0] lv0, lv1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  // Default configuration.
  game_tick_scheduler dut0 (
    .clk              (clk),
    .reset            (reset),
    .frame_pulse      (frame_pulse),
    .button_up_raw    (bu_raw),
    .button_down_raw  (bd_raw),
    .game_start_pulse (start_p),
    .game_over_pulse  (over_p),
    .game_tick        (gt0),
    .button_up        (bu0),
    .button_down      (bd0),
    .level            (lv0),
    .overrun          (ov0)
  );

  // Fast configuration: one frame per sequence, long gap, quick levels.
  game_tick_scheduler #(
    .FRAME_DIV_INIT (1),
    .FRAME_DIV_MIN  (1),
    .LEVEL_TICKS    (2),
    .MAX_LEVEL      (5),
    .PHASE_GAP      (3)
  ) dut1 (
    .clk              (clk),
    .reset            (reset),
    .frame_pulse      (frame_pulse),
    .button_up_raw    (bu_raw),
    .button_down_raw  (bd_raw),
    .game_start_pulse (start_p),
    .game_over_pulse  (over_p),
    .game_tick        (gt1),
    .button_up        (bu1),
    .button_down      (bd1),
    .level            (lv1),
    .overrun          (ov1)
  );

  // Reference model: configuration per DUT and abstract state.
  int p_init[2] = '{4, 1};
  int p_min [2] = '{1, 1};
  int p_lt  [2] = '{128, 2};
  int p_max [2] = '{15, 5};
  int p_gap [2] = '{1, 3};

  int m_level[2], m_run[2], m_tcnt[2], m_fcnt[2], m_req[2];
  int m_ovr[2], m_pos[2], m_sticky[2], m_bu[2], m_bd[2];

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_level[k] = 0; m_run[k] = 0; m_tcnt[k] = 0; m_fcnt[k] = 0; m_req[k] = 0;
      m_ovr[k] = 0; m_pos[k] = 0; m_sticky[k] = 0; m_bu[k] = 0; m_bd[k] = 0;
    end
  endtask

  // One clock edge of behaviour; m_pos is the position within a sequence (0 = idle).
  task automatic model_step(input int k);
    int div, last;
    bit term, idle, go;
    div  = p_init[k] - m_level[k];
    if (div < p_min[k]) div = p_min[k];
    term = frame_pulse && (m_fcnt[k] + 1 >= div);
    last = p_gap[k] + 2;
    idle = (m_pos[k] == 0);
    go   = idle && (m_req[k] != 0);

    if (go) begin
      m_bu[k] = m_sticky[k] | int'(bu_raw);
      m_bd[k] = int'(bd_raw);
      m_sticky[k] = 0;
    end else if (bu_raw) begin
      m_sticky[k] = 1;
    end

    if (start_p) begin
      m_level[k] = 0;
      m_tcnt[k]  = 0;
    end else if (m_pos[k] == last && m_run[k] != 0) begin
      m_tcnt[k]++;
      if (m_tcnt[k] == p_lt[k]) begin
        m_tcnt[k] = 0;
        if (m_level[k] < p_max[k]) m_level[k]++;
      end
    end
    if (over_p)       m_run[k] = 0;
    else if (start_p) m_run[k] = 1;

    if (go)         m_pos[k] = 1;
    else if (!idle) m_pos[k] = (m_pos[k] == last) ? 0 : m_pos[k] + 1;

    if (go) m_req[k] = int'(term);
    else if (term) begin
      if (m_req[k] != 0) m_ovr[k] = 1;
      m_req[k] = 1;
    end

    if (frame_pulse) m_fcnt[k] = term ? 0 : m_fcnt[k] + 1;
  endtask

  task automatic compare_all();
    int exp_gt;
    for (int k = 0; k < 2; k++) begin
      exp_gt = (m_pos[k] == 1) ? 1 : (m_pos[k] == p_gap[k] + 2) ? 2 : 0;
      if (k == 0) begin
        check_eq("dut0.game_tick", gt0, exp_gt);
        check_eq("dut0.button_up", bu0, m_bu[0]);
        check_eq("dut0.button_down", bd0, m_bd[0]);
        check_eq("dut0.level", lv0, m_level[0]);
        check_eq("dut0.overrun", ov0, m_ovr[0]);
      end else begin
        check_eq("dut1.game_tick", gt1, exp_gt);
        check_eq("dut1.button_up", bu1, m_bu[1]);
        check_eq("dut1.button_down", bd1, m_bd[1]);
        check_eq("dut1.level", lv1, m_level[1]);
        check_eq("dut1.overrun", ov1, m_ovr[1]);
      end
    end
  endtask

  // Drive inputs on the falling edge, step the model on the rising edge, compare just after.
  task automatic cycle(input bit fp, input bit bu, input bit bd, input bit st, input bit ov);
    @(negedge clk);
    frame_pulse = fp; bu_raw = bu; bd_raw = bd; start_p = st; over_p = ov;
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
    #1 compare_all();
  endtask

  task automatic run_frames(input int n, input int pmin, input int pmax, input bit rnd_btn);
    int  per;
    bit  b_up, b_dn;
    for (int i = 0; i < n; i++) begin
      per = int'($urandom_range(pmax, pmin));
      for (int j = 0; j < per; j++) begin
        b_up = rnd_btn && ($urandom_range(7, 0) == 0);
        b_dn = rnd_btn && ($urandom_range(1, 0) == 1);
        cycle(j == 0, b_up, b_dn, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_pulse = 0; bu_raw = 0; bd_raw = 0; start_p = 0; over_p = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_vel, budget;
    bit b_up, b_dn, st, ov, fp;

    reset = 1'b1;
    frame_pulse = 0; bu_raw = 0; bd_raw = 0; start_p = 0; over_p = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 compare_all();
    reset = 1'b0;

    // Frame pulse every 20 cycles at default speed, not running.
    n_vel = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 1; j < 20; j++) begin
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (gt0[0]) n_vel++;
        // Pulse is sampled on the edge closing its call; PH0 shows after the next edge,
        // PH1 two cycles after PH0.
        if (i % 4 == 3 && j == 1) check_eq("lat_vel", gt0, 2'b01);
        if (i % 4 == 3 && j == 2) check_eq("gap_quiet", gt0, 2'b00);
        if (i % 4 == 3 && j == 3) check_eq("lat_pos", gt0, 2'b10);
      end
    end
    check_eq("vel_count", n_vel, 3);
    check_eq("level_idle", lv0, 0);

    // One-cycle up press between sequences, visible for exactly one sequence.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (19) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("btn_snap_set", bu0, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (19) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("btn_snap_clr", bu0, 0);

    // Fully random traffic including start/over pulses.
    for (int i = 0; i < 800; i++) begin
      fp   = ($urandom_range(2, 0) == 0);
      b_up = ($urandom_range(5, 0) == 0);
      b_dn = ($urandom_range(1, 0) == 1);
      st   = ($urandom_range(49, 0) == 0);
      ov   = ($urandom_range(49, 0) == 0);
      cycle(fp, b_up, b_dn, st, ov);
    end

    // Long running game: level climbs and saturates.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frames(3000, 4, 6, 1'b1);
    check_eq("level_sat0", lv0, 15);
    check_eq("level_sat1", lv1, 5);

    // Asynchronous reset in the middle of a gap.
    budget = 0;
    while (m_pos[0] != 2 && budget < 200) begin
      cycle((budget % 5) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
      budget++;
    end
    check_eq("gap_reached", (m_pos[0] == 2) ? 1 : 0, 1);
    check_eq("pre_rst_bu", bu0, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_tick", gt0, 0);
    check_eq("arst_level", lv0, 0);
    check_eq("arst_bu", bu0, 0);
    check_eq("arst_bd", bd0, 0);
    check_eq("arst_level1", lv1, 0);
    check_eq("arst_bu1", bu1, 0);
    model_reset();
    frame_pulse = 0; bu_raw = 0; bd_raw = 0; start_p = 0; over_p = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Start and over together: not running, level must not move.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frames(800, 4, 4, 1'b1);
    check_eq("level_frozen", lv0, 0);

    // Back-to-back requests on the fast configuration: pending then overrun.
    do_reset();
    n_vel = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (gt1[0]) n_vel++;
    check_eq("ovr_before", ov1, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ovr_after", ov1, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (gt1[0]) n_vel++;
    end
    check_eq("pending_served", n_vel, 2);
    check_eq("ovr_dut0", ov0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
- Sequences the shared adder datapath in the player physics block.
- Converts the display's once-per-frame pulse into the two-phase game_tick[1:0] strobe: phase 0 updates velocity, phase 1 updates position.
- Captures button activity between ticks so it is presented stably to the player controller.
- Raises game speed (fewer frames per tick) as a running game progresses; sits between the display timing generator and the player controller/physics.

Parameters:
- FRAME_DIV_INIT, 4, frames per tick sequence at level 0 (1..15)
- FRAME_DIV_MIN, 1, floor on frames per tick sequence (1..FRAME_DIV_INIT)
- LEVEL_TICKS, 128, completed running tick sequences per level increment (2..256)
- MAX_LEVEL, 15, saturation value of level (<=15)
- PHASE_GAP, 1, idle cycles between game_tick[0] and game_tick[1] (0..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_pulse  in  1  one-cycle pulse per display frame
- button_up_raw  in  1  synchronised up button, level
- button_down_raw  in  1  synchronised down button, level
- game_start_pulse  in  1  one-cycle, from player controller
- game_over_pulse  in  1  one-cycle, from player controller
- game_tick  out  2  [0] velocity-phase strobe, [1] position-phase strobe
- button_up  out  1  latched up-press snapshot
- button_down  out  1  latched down-level snapshot
- level  out  4  current difficulty level
- overrun  out  1  sticky: a sequence request arrived while one was already pending

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset. All state is cleared on reset assertion, independent of clk.
- Reset values: game_tick=0, button_up=0, button_down=0, level=0, overrun=0, FSM=IDLE, counters=0, running=0.
- div = max(FRAME_DIV_INIT - level, FRAME_DIV_MIN), combinational from level, 4-bit unsigned.
- frame_cnt (4b) increments on each frame_pulse. When frame_pulse arrives with frame_cnt == div-1:
  - frame_cnt wraps to 0;
  - a sequence request is raised.
- If div shrinks below frame_cnt+1, the next frame_pulse treats it as terminal (>= compare).
- FSM states:
  - IDLE -> PH0 on request; request consumed.
  - PH0: game_tick=01 for exactly one cycle -> GAP if PHASE_GAP>0, else PH1.
  - GAP: counts PHASE_GAP cycles, game_tick=00 -> PH1.
  - PH1: game_tick=11? No — game_tick=10 for exactly one cycle -> IDLE.
- game_tick[0] and game_tick[1] are never high together. Latency from the triggering frame_pulse to game_tick[0] is 2 cycles (request register, then PH0 output).
- Request arriving while the FSM is not IDLE: held in a one-deep pending flag and serviced on return to IDLE. A second request while the flag is already set is dropped and sets overrun (cleared only by reset).
- Button capture:
  - up_sticky is set on any cycle with button_up_raw=1.
  - On IDLE->PH0: button_up <= up_sticky | button_up_raw, button_down <= button_down_raw, and up_sticky is cleared in the same cycle.
  - A press during PH0/GAP/PH1 lands in up_sticky for the next sequence.
  - Outputs hold until the next IDLE->PH0 transition.
- running flag:
  - set by game_start_pulse;
  - cleared by game_over_pulse;
  - if both arrive in the same cycle, game_over wins.
- game_start_pulse also clears level and tick_cnt.
- tick_cnt (8b) increments on PH1 exit while running. At LEVEL_TICKS-1 it wraps to 0 and level increments, saturating at MAX_LEVEL.
- Level is frozen while not running.
- Ticks continue to be generated in every state, running or not, because the controller needs them to detect start/restart.

Decomposition:
- Shared package holds:
  - game_tick bit indices (TICK_VEL=0, TICK_POS=1);
  - FSM state encoding (IDLE, PH0, GAP, PH1 as 2-bit constants);
  - level width (4) and tick-counter width (8).
- One natural sub-module, frame_divider: frame_cnt, compare against div, request/pending/overrun logic.
- FSM, button capture and level logic stay in game_tick_scheduler.

Test Plan:
- Reset, then frame_pulse every 20 cycles, defaults -> game_tick[0] 2 cycles after every 4th frame_pulse, game_tick[1] exactly 2 cycles after game_tick[0], level stays 0 with no start.
- button_up_raw high for 1 cycle between sequences, then released -> button_up=1 through next PH0/PH1; the following sequence shows button_up=0.
- game_start_pulse, then 128 sequences -> level=1 and div=3, so the next sequence follows 3 frame_pulses; continue to level 3 -> div=1, one sequence per frame; level saturates at 15.
- game_over_pulse and game_start_pulse in the same cycle, then 200 sequences -> level remains 0, tick_cnt does not advance.
- frame_pulse on consecutive cycles with div=1 and PHASE_GAP=3 -> second request pending and serviced back-to-back, third sets overrun=1.
- reset asserted mid-GAP, asynchronously -> game_tick=00, level=0, button outputs 0 immediately, before the next clk edge.
